// File: rtl/scan_sequencer.sv
// Channel scanner feeding a 4-to-16 decoder: steps through the channels set in
// chan_mask in ascending circular order. Each channel gets BLANK_CYCLES of
// decoder-enable-low blanking, then max(dwell,1) cycles of enable-high dwell.
module scan_sequencer #(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_single,
  input  logic [15:0]        chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         sel_out,
  output logic               sel_en,
  output logic               busy,
  output logic               chan_strobe,
  output logic               pass_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  // Blank counter counts down from BLANK_CYCLES-1; kept at least 1 bit wide
  // so a zero-blank build still elaborates (the counter is then never loaded).
  localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BCW-1:0] BLANK_LOAD =
    BCW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [1:0]         state, state_nx;
  logic [BCW-1:0]     blank_cnt, blank_nx;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nx;
  logic               single_r, single_nx;
  logic [3:0]         sel_nx;
  logic               en_nx, busy_nx, stb_nx, pd_nx;

  logic [3:0]         low_idx;
  logic [3:0]         nxt_idx;
  logic               wrap;
  logic [DWELL_W-1:0] dwell_load;
  logic               start_ok;
  logic               enter;
  logic               go_idle;

  // Lowest set bit of the mask: first channel of a pass started from IDLE.
  // Scanning downward lets the smallest index overwrite larger ones.
  always_comb begin
    low_idx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (chan_mask[k]) low_idx = 4'(k);
    end
  end

  // First set bit strictly after sel_out, circular. Offsets are scanned from
  // largest to smallest so the nearest one wins; if only the current channel
  // is set, the default (sel_out itself) is the answer, which counts as a wrap.
  always_comb begin
    nxt_idx = sel_out;
    for (int k = 15; k >= 1; k--) begin
      if (chan_mask[sel_out + 4'(k)]) nxt_idx = sel_out + 4'(k);
    end
  end

  assign wrap       = (nxt_idx <= sel_out);
  // Counter holds remaining dwell cycles minus one, so dwell=0 behaves as 1.
  assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign start_ok   = start && !stop && (chan_mask != 16'h0000);

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_nx  = state;
    sel_nx    = sel_out;
    en_nx     = sel_en;
    busy_nx   = busy;
    stb_nx    = 1'b0;
    pd_nx     = 1'b0;
    blank_nx  = blank_cnt;
    dwell_nx  = dwell_cnt;
    single_nx = single_r;
    enter     = 1'b0;
    go_idle   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_ok) begin
          sel_nx    = low_idx;
          single_nx = mode_single;
          enter     = 1'b1;
        end
      end
      S_BLANK: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (blank_cnt == '0) begin
          state_nx = S_DWELL;
          en_nx    = 1'b1;
          stb_nx   = 1'b1;
          dwell_nx = dwell_load;
        end else begin
          blank_nx = blank_cnt - BCW'(1);
        end
      end
      S_DWELL: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (dwell_cnt == '0) begin
          // Mask emptied under us: abandon the pass silently.
          if (chan_mask == 16'h0000) begin
            go_idle = 1'b1;
          end else begin
            pd_nx = wrap;
            if (wrap && single_r) begin
              go_idle = 1'b1;
            end else begin
              sel_nx = nxt_idx;
              enter  = 1'b1;
            end
          end
        end else begin
          dwell_nx = dwell_cnt - DWELL_W'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_nx = S_IDLE;
      en_nx    = 1'b0;
      busy_nx  = 1'b0;
    end

    // Entering a channel: blank first unless the build has no blanking, in
    // which case dwell starts immediately and sel_en stays high across the
    // channel change.
    if (enter) begin
      busy_nx = 1'b1;
      if (BLANK_CYCLES == 0) begin
        state_nx = S_DWELL;
        en_nx    = 1'b1;
        stb_nx   = 1'b1;
        dwell_nx = dwell_load;
      end else begin
        state_nx = S_BLANK;
        en_nx    = 1'b0;
        blank_nx = BLANK_LOAD;
      end
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      blank_cnt   <= '0;
      dwell_cnt   <= '0;
      single_r    <= 1'b0;
      sel_out     <= 4'd0;
      sel_en      <= 1'b0;
      busy        <= 1'b0;
      chan_strobe <= 1'b0;
      pass_done   <= 1'b0;
    end else begin
      state       <= state_nx;
      blank_cnt   <= blank_nx;
      dwell_cnt   <= dwell_nx;
      single_r    <= single_nx;
      sel_out     <= sel_nx;
      sel_en      <= en_nx;
      busy        <= busy_nx;
      chan_strobe <= stb_nx;
      pass_done   <= pd_nx;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a BLANK_CYCLES=2 and a BLANK_CYCLES=0 instance
// share stimulus; each is checked against a timeline model that tracks the
// channel and the cycle position within that channel's blank+dwell period.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode_single = 1'b0;
  logic [15:0] chan_mask = 16'h0;
  logic [15:0] dwell = 16'h0;

  logic [3:0] sel2, sel0;
  logic       en2, busy2, stb2, pd2;
  logic       en0, busy0, stb0, pd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(16), .BLANK_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_single(mode_single), .chan_mask(chan_mask), .dwell(dwell),
    .sel_out(sel2), .sel_en(en2), .busy(busy2),
    .chan_strobe(stb2), .pass_done(pd2));

  scan_sequencer #(.DWELL_W(16), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_single(mode_single), .chan_mask(chan_mask), .dwell(dwell),
    .sel_out(sel0), .sel_en(en0), .busy(busy0),
    .chan_strobe(stb0), .pass_done(pd0));

  wire [7:0] got2 = {sel2, en2, busy2, stb2, pd2};
  wire [7:0] got0 = {sel0, en0, busy0, stb0, pd0};

  // ---------------- reference model ----------------
  typedef struct {
    bit active;
    int ch;
    int pos;    // cycle index inside current channel period (blank then dwell)
    int dlen;   // dwell length sampled for this channel
    bit single;
    bit pd;
  } model_t;

  model_t m2, m0;

  function automatic model_t model_reset();
    model_t r;
    r.active = 0; r.ch = 0; r.pos = 0; r.dlen = 1; r.single = 0; r.pd = 0;
    return r;
  endfunction

  function automatic int low_ch(logic [15:0] m);
    for (int c = 0; c < 16; c++) if (m[c]) return c;
    return 0;
  endfunction

  function automatic int next_ch(logic [15:0] m, int cur);
    for (int k = 1; k <= 16; k++) if (m[(cur + k) % 16]) return (cur + k) % 16;
    return cur;
  endfunction

  function automatic model_t step(model_t s, int b, bit st, bit sp, bit ms,
                                  logic [15:0] m, int dw);
    model_t n;
    int d;
    int nx;
    n = s;
    d = (dw == 0) ? 1 : dw;
    n.pd = 0;
    if (!s.active) begin
      if (st && !sp && m != 16'h0) begin
        n.active = 1; n.ch = low_ch(m); n.single = ms; n.pos = 0;
        if (b == 0) n.dlen = d;
      end
    end else if (sp) begin
      n.active = 0;
    end else if (s.pos == b + s.dlen - 1) begin
      if (m == 16'h0) begin
        n.active = 0;
      end else begin
        nx = next_ch(m, s.ch);
        if (nx <= s.ch) n.pd = 1;
        if (nx <= s.ch && s.single) n.active = 0;
        else begin
          n.ch = nx; n.pos = 0;
          if (b == 0) n.dlen = d;
        end
      end
    end else begin
      n.pos = s.pos + 1;
      if (n.pos == b) n.dlen = d;
    end
    return n;
  endfunction

  function automatic logic [7:0] expv(model_t s, int b);
    return {4'(s.ch), s.active && s.pos >= b, s.active,
            s.active && s.pos == b, s.pd};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2 <= model_reset();
      m0 <= model_reset();
    end else begin
      m2 <= step(m2, 2, start, stop, mode_single, chan_mask, int'(dwell));
      m0 <= step(m0, 0, start, stop, mode_single, chan_mask, int'(dwell));
    end
  end

  // Stimulus-only helper: abort any scan in progress.
  task automatic go_idle();
    stop = 1'b1;
    @(posedge clk); #2;
    stop = 1'b0;
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks += 2;
    if (got2 !== 8'h00) begin errors++; $display("FAIL reset_b2 got %h exp 00", got2); end
    if (got0 !== 8'h00) begin errors++; $display("FAIL reset_b0 got %h exp 00", got0); end
    rst_n = 1'b1;
    @(posedge clk); #2;
    chan_mask = 16'h0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      checks += 2;
      if (busy2 !== 1'b0) begin errors++; $display("FAIL empty_mask_start_b2 busy got %b exp 0", busy2); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL empty_mask_start_b0 got %h exp %h", got0, expv(m0, 0)); end
    end
  endtask

  task automatic test_single_pass();
    int seq[$];
    int nstb0, npd, nen;
    nstb0 = 0; npd = 0; nen = 0;
    chan_mask = 16'h8421; dwell = 16'd3; mode_single = 1'b1; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL single_pass_b2 cyc %0d got %h exp %h", i, got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL single_pass_b0 cyc %0d got %h exp %h", i, got0, expv(m0, 0)); end
      if (stb2) seq.push_back(int'(sel2));
      if (stb0) nstb0++;
      if (pd2) npd++;
      if (en2) nen++;
    end
    checks += 5;
    if (seq.size() != 4 || seq[0] != 0 || seq[1] != 5 || seq[2] != 10 || seq[3] != 15) begin
      errors++; $display("FAIL single_pass_seq got %p exp '{0,5,10,15}", seq);
    end
    if (nstb0 != 4) begin errors++; $display("FAIL single_pass_strobes_b0 got %0d exp 4", nstb0); end
    if (npd != 1) begin errors++; $display("FAIL single_pass_done got %0d exp 1", npd); end
    if (nen != 12) begin errors++; $display("FAIL single_pass_en_cycles got %0d exp 12", nen); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL single_pass_end_busy got %b exp 0", busy2); end
  endtask

  task automatic test_continuous();
    int npd2, npd0;
    npd2 = 0; npd0 = 0;
    chan_mask = 16'h0006; dwell = 16'd1; mode_single = 1'b0; start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL continuous_b2 cyc %0d got %h exp %h", i, got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL continuous_b0 cyc %0d got %h exp %h", i, got0, expv(m0, 0)); end
      if (pd2) npd2++;
      if (pd0) npd0++;
    end
    checks += 2;
    if (npd2 != 3) begin errors++; $display("FAIL continuous_pd_b2 got %0d exp 3", npd2); end
    if (npd0 != 11) begin errors++; $display("FAIL continuous_pd_b0 got %0d exp 11", npd0); end
    go_idle();
    checks += 2;
    if (busy2 !== 1'b0 || en2 !== 1'b0) begin errors++; $display("FAIL continuous_stop_b2 busy/en got %b%b exp 00", busy2, en2); end
    if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL continuous_stop_b0 got %h exp %h", got0, expv(m0, 0)); end
  endtask

  task automatic test_live_mask();
    int first_after, npd;
    bit seen;
    first_after = -1; npd = 0; seen = 0;
    chan_mask = 16'h00FF; dwell = 16'd4; mode_single = 1'b0; start = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL live_wait_b2 got %h exp %h", got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL live_wait_b0 got %h exp %h", got0, expv(m0, 0)); end
      if (sel2 == 4'd2 && en2) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL live_wait_timeout got no dwell on ch2 exp dwell on ch2"); end
    chan_mask = 16'h0080;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #2;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL live_mask_b2 cyc %0d got %h exp %h", i, got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL live_mask_b0 cyc %0d got %h exp %h", i, got0, expv(m0, 0)); end
      if (stb2 && first_after < 0) first_after = int'(sel2);
      if (pd2) npd++;
    end
    checks += 2;
    if (first_after != 7) begin errors++; $display("FAIL live_next_chan got %0d exp 7", first_after); end
    if (npd < 3) begin errors++; $display("FAIL live_self_wrap_pd got %0d exp >=3", npd); end
    go_idle();
  endtask

  task automatic test_edges();
    int nen0, nen2, run, maxrun, npd;
    bit first_en0, seen;
    nen0 = 0; nen2 = 0; run = 0; maxrun = 0; npd = 0; seen = 0;
    chan_mask = 16'h8421; dwell = 16'd0; mode_single = 1'b1; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL dwell0_b2 cyc %0d got %h exp %h", i, got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL dwell0_b0 cyc %0d got %h exp %h", i, got0, expv(m0, 0)); end
      if (i == 0) first_en0 = en0;
      if (en0) nen0++;
      if (en2) begin nen2++; run++; if (run > maxrun) maxrun = run; end else run = 0;
    end
    checks += 4;
    if (first_en0 !== 1'b1) begin errors++; $display("FAIL noblank_en_latency got %b exp 1", first_en0); end
    if (nen0 != 4) begin errors++; $display("FAIL noblank_en_cycles got %0d exp 4", nen0); end
    if (nen2 != 4) begin errors++; $display("FAIL dwell0_en_cycles got %0d exp 4", nen2); end
    if (maxrun != 1) begin errors++; $display("FAIL dwell0_en_run got %0d exp 1", maxrun); end

    chan_mask = 16'h0011; dwell = 16'd5; mode_single = 1'b0; start = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (stb2) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mask0_wait_timeout got no strobe exp strobe"); end
    chan_mask = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL mask0_b2 cyc %0d got %h exp %h", i, got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL mask0_b0 cyc %0d got %h exp %h", i, got0, expv(m0, 0)); end
      if (pd2 || pd0) npd++;
    end
    checks += 2;
    if (npd != 0) begin errors++; $display("FAIL mask0_pass_done got %0d exp 0", npd); end
    if (busy2 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL mask0_idle busy got %b%b exp 00", busy2, busy0); end
  endtask

  task automatic test_simultaneous();
    int seq[$];
    bit seen, en_seen;
    seen = 0; en_seen = 0;
    chan_mask = 16'h0003; dwell = 16'd2; mode_single = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; stop = 1'b0;
    checks += 2;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL start_stop_idle_b2 busy got %b exp 0", busy2); end
    if (busy0 !== 1'b0) begin errors++; $display("FAIL start_stop_idle_b0 busy got %b exp 0", busy0); end

    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      stop = 1'b0;
      if (en2) en_seen = 1;
      checks += 2;
      if (busy2 !== 1'b0) begin errors++; $display("FAIL stop_in_blank_busy cyc %0d got %b exp 0", i, busy2); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL stop_in_blank_b0 got %h exp %h", got0, expv(m0, 0)); end
    end
    checks++;
    if (en_seen) begin errors++; $display("FAIL stop_in_blank_en got 1 exp 0"); end

    start = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (en2) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL busy_start_wait_timeout got no dwell exp dwell"); end
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL busy_start_b2 cyc %0d got %h exp %h", i, got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL busy_start_b0 cyc %0d got %h exp %h", i, got0, expv(m0, 0)); end
      if (stb2) seq.push_back(int'(sel2));
    end
    checks++;
    if (seq.size() < 4 || seq[0] != 1 || seq[1] != 0 || seq[2] != 1 || seq[3] != 0) begin
      errors++; $display("FAIL busy_start_seq got %p exp '{1,0,1,0,...}", seq);
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 39) == 0);
      mode_single = 1'($urandom_range(0, 1));
      dwell = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 14) == 0)
        chan_mask = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
      @(posedge clk); #2;
      checks += 2;
      if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL random_b2 cyc %0d got %h exp %h", i, got2, expv(m2, 2)); end
      if (got0 !== expv(m0, 0)) begin errors++; $display("FAIL random_b0 cyc %0d got %h exp %h", i, got0, expv(m0, 0)); end
    end
    start = 1'b0; stop = 1'b0;
    go_idle();
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 0;
    chan_mask = 16'hFFFF; dwell = 16'd6; mode_single = 1'b0; start = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (en2 && sel2 != 4'd0) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL async_wait_timeout got no dwell exp dwell on nonzero ch"); end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (got2 !== 8'h00) begin errors++; $display("FAIL async_reset_b2 got %h exp 00", got2); end
    if (got0 !== 8'h00) begin errors++; $display("FAIL async_reset_b0 got %h exp 00", got0); end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (got2 !== expv(m2, 2)) begin errors++; $display("FAIL async_release_b2 got %h exp %h", got2, expv(m2, 2)); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_continuous();
    test_live_mask();
    test_edges();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
